// File: rtl/bsg_fifo_1rw_unbuncher.sv
// Read-side drain for a double-width 1RW FIFO ram: fetches pair-words, buffers two, emits single words low half first.
// Optional BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN adds mem_half_i so a pair may carry only its low word.
module bsg_fifo_1rw_unbuncher #(
  parameter int width_p = 16  // must be set by the instantiating design
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   mem_empty_i,
  input  logic                   mem_ready_i,
  output logic                   mem_v_o,
  input  logic [2*width_p-1:0]   mem_data_i,
`ifdef BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN
  input  logic                   mem_half_i,
`endif
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   yumi_i
);

  typedef struct packed {
    logic                 half;
    logic [2*width_p-1:0] data;
  } entry_t;

  entry_t [1:0] buf_q, buf_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         inflight_q, inflight_d;
  logic         half_q, half_d;

  logic capture, pop, head_half;
  entry_t in_entry;
  entry_t head;

  assign head = buf_q[rd_ptr_q];

`ifdef BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN
  assign head_half     = head.half;
  assign in_entry.half = mem_half_i;
`else
  assign head_half     = 1'b0;
  assign in_entry.half = 1'b0;
`endif
  assign in_entry.data = mem_data_i;

  // Counting the in-flight read keeps the buffer from ever being oversubscribed.
  assign mem_v_o = ~mem_empty_i & ((occ_q + {1'b0, inflight_q}) < 2'd2);
  assign v_o     = (occ_q != 2'd0);
  assign data_o  = half_q ? head.data[2*width_p-1:width_p] : head.data[width_p-1:0];

  assign capture = inflight_q;
  assign pop     = yumi_i & (half_q | head_half);

  always_comb begin
    buf_d      = buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    half_d     = half_q;
    inflight_d = mem_v_o & mem_ready_i;

    if (capture) begin
      buf_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (yumi_i) half_d = ~pop;
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Reset drops inflight_q, so a read granted just before reset is never captured.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      buf_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      half_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      half_q     <= half_d;
    end
  end

`ifndef SYNTHESIS
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  a_no_overflow:  assert property (@(posedge clk_i) disable iff (!reset_n_i) inflight_q |-> (occ_q != 2'd2));
`endif

endmodule

// File: tb/tb_bsg_fifo_1rw_unbuncher.sv
// Directed bench for bsg_fifo_1rw_unbuncher: a small 1RW ram model feeds the block and output words are checked in order.
module tb_bsg_fifo_1rw_unbuncher;
  localparam int W = 16;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic           mem_empty_i;
  logic           mem_ready_i;
  logic           mem_v_o;
  logic [2*W-1:0] mem_data_i;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           yumi_i;
`ifdef BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN
  logic           mem_half_i;
`endif

  int checks = 0;
  int errors = 0;

  // ram model: entries loaded by the stimulus, popped on grant, data returned next cycle
  logic [2*W-1:0] ram_mem [0:63];
  logic           ram_half [0:63];
  int             ram_wr = 0;
  int             ram_rd = 0;
  int             grant_cnt = 0;
  logic           rhalf = 1'b0;

  assign mem_empty_i = (ram_rd == ram_wr);

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_v_o && mem_ready_i) begin
      mem_data_i <= ram_mem[ram_rd % 64];
      rhalf      <= ram_half[ram_rd % 64];
      ram_rd     <= ram_rd + 1;
      grant_cnt  <= grant_cnt + 1;
    end
  end

  bsg_fifo_1rw_unbuncher #(.width_p(W)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .mem_empty_i (mem_empty_i),
    .mem_ready_i (mem_ready_i),
    .mem_v_o     (mem_v_o),
    .mem_data_i  (mem_data_i),
`ifdef BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN
    .mem_half_i  (mem_half_i),
`endif
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i)
  );

`ifdef BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN
  assign mem_half_i = rhalf;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic load(input logic [2*W-1:0] val, input logic half);
    ram_mem[ram_wr % 64]  = val;
    ram_half[ram_wr % 64] = half;
    ram_wr++;
    #1;
  endtask

  // Consume expected words base..base+n-1; optional ready toggling 1,0,0,1 and gap-free check.
  task automatic drain(input int n, input int base, input bit tog, input bit gapless);
    int  got = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    while (got < n && cyc < 300) begin
      if (tog) mem_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      if (gapless && started) chk("no_gap", {31'd0, v_o}, 32'd1);
      if (v_o) begin
        chk("drain_data", {16'd0, data_o}, base + got);
        yumi_i  = 1'b1;
        got++;
        started = 1'b1;
      end else begin
        yumi_i = 1'b0;
      end
      step();
      cyc++;
    end
    yumi_i      = 1'b0;
    mem_ready_i = 1'b1;
    chk("drain_cnt", got, n);
  endtask

  initial begin
    int g0;
    reset_n_i   = 1'b0;
    mem_ready_i = 1'b1;
    yumi_i      = 1'b0;
    mem_data_i  = '0;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i]  = '0;
      ram_half[i] = 1'b0;
    end

    // reset with empty ram
    #3;
    chk("rst_v", {31'd0, v_o}, 32'd0);
    chk("rst_mem_v", {31'd0, mem_v_o}, 32'd0);
    chk("rst_data", {16'd0, data_o}, 32'd0);
    step(); step();
    reset_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_v", {31'd0, v_o}, 32'd0);
      chk("idle_mem_v", {31'd0, mem_v_o}, 32'd0);
    end

    // single pair: grant, data next cycle, output the cycle after
    load(32'hBBBB_AAAA, 1'b0);
    chk("one_req", {31'd0, mem_v_o}, 32'd1);
    chk("one_v_t", {31'd0, v_o}, 32'd0);
    step();
    chk("one_v_t1", {31'd0, v_o}, 32'd0);
    chk("one_noreq_t1", {31'd0, mem_v_o}, 32'd0);
    step();
    chk("one_v_t2", {31'd0, v_o}, 32'd1);
    chk("one_lo", {16'd0, data_o}, 32'hAAAA);
    yumi_i = 1'b1;
    step();
    chk("one_v_hi", {31'd0, v_o}, 32'd1);
    chk("one_hi", {16'd0, data_o}, 32'hBBBB);
    step();
    yumi_i = 1'b0;
    chk("one_empty", {31'd0, v_o}, 32'd0);

    // 8 pairs streamed at full rate
    for (int k = 0; k < 8; k++) load({16'(2*k+1), 16'(2*k)}, 1'b0);
    drain(16, 0, 1'b0, 1'b1);
    step();
    chk("stream_done", {31'd0, v_o}, 32'd0);

    // back-pressure: only two pairs may be fetched
    g0 = grant_cnt;
    for (int k = 0; k < 4; k++) load({16'(16+2*k+1), 16'(16+2*k)}, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("bp_grants", grant_cnt - g0, 2);
    chk("bp_noreq", {31'd0, mem_v_o}, 32'd0);
    chk("bp_v", {31'd0, v_o}, 32'd1);
    chk("bp_head", {16'd0, data_o}, 32'd16);
    drain(8, 16, 1'b0, 1'b0);
    step();
    chk("bp_done", {31'd0, v_o}, 32'd0);

    // denied grants are retried without loss or duplication
    g0 = grant_cnt;
    for (int k = 0; k < 4; k++) load({16'(24+2*k+1), 16'(24+2*k)}, 1'b0);
    drain(8, 24, 1'b1, 1'b0);
    step(); step();
    chk("tog_done", {31'd0, v_o}, 32'd0);
    chk("tog_grants", grant_cnt - g0, 4);

    // reset one cycle after a grant discards the returned pair
    load(32'hDEAD_BEEF, 1'b0);
    chk("rr_req", {31'd0, mem_v_o}, 32'd1);
    step();
    reset_n_i = 1'b0;
    #1;
    chk("rr_v_in_rst", {31'd0, v_o}, 32'd0);
    step(); step();
    reset_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_v", {31'd0, v_o}, 32'd0);
    end

`ifdef BSG_FIFO_1RW_UNBUNCHER_HALF_VALID_EN
    // odd trailing word: only the low half is emitted
    load(32'h0000_0007, 1'b1);
    drain(1, 7, 1'b0, 1'b0);
    step();
    chk("half_done", {31'd0, v_o}, 32'd0);
    chk("half_ptr_lo", {16'd0, data_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
